// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package if_prefetch_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ROM_DEPTH  = 256;
  localparam int unsigned FETCH_FIFO_DEPTH   = 4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INST_NOP           = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with synchronous flush; head is visible on data_o
// whenever the queue is non-empty. DEPTH must be a power of two, at least 2.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the head slot that the push overwrites.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: fetch PC, ROM addressing, prefetch queue toward
// decode, and jump/branch redirect with queue flush.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ROM_DEPTH  = DEFAULT_ROM_DEPTH,
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  localparam int unsigned          ROM_AW     = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_instr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic                  jump_en_i,
  input  logic [DATA_WIDTH-1:0] jump_addr_i
);

  logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [2*DATA_WIDTH-1:0] head;
  logic                    full, empty;
  logic                    push, pop;

  assign rom_addr_o = fetch_pc_q[ROM_AW+1:2];

  // A redirect suppresses both push and pop; the flush discards the head.
  assign pop  = instr_valid_o & instr_ready_i & ~jump_en_i;
  assign push = ~jump_en_i & (~full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (jump_en_i)  fetch_pc_d = jump_addr_i & ~DATA_WIDTH'(3);
    else if (push)  fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  sync_fifo_fwft #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jump_en_i),
    .data_i  ({fetch_pc_q, rom_instr_i}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign instr_valid_o = ~empty;
  assign instr_o       = empty ? DATA_WIDTH'(INST_NOP) : head[DATA_WIDTH-1:0];
  assign instr_pc_o    = empty ? '0 : head[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model checked every cycle, plus
// directed literal expectations for latency, stall, redirect, wrap and reset.
module tb_if_prefetch;

  localparam int unsigned RD = 256;
  localparam int unsigned FD = 4;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] instr, instr_pc;
  logic        valid;
  logic        ready = 1'b0;
  logic        jump  = 1'b0;
  logic [31:0] jaddr = 32'h0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = 32'h0;

  always #5 clk = ~clk;

  assign rom_instr = 32'h1000_0000 + 32'(rom_addr);

  if_prefetch #(
    .DATA_WIDTH (32),
    .ROM_DEPTH  (RD),
    .FIFO_DEPTH (FD),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rom_addr_o    (rom_addr),
    .rom_instr_i   (rom_instr),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .jump_en_i     (jump),
    .jump_addr_i   (jaddr)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % RD);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_head(input string name, input logic [31:0] ins, input logic [31:0] pc);
    check({name, "_valid"}, 64'(valid), 64'd1);
    check({name, "_instr"}, 64'(instr), 64'(ins));
    check({name, "_pc"}, 64'(instr_pc), 64'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetch order queue, capacity FD, redirect empties it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      mpc = 32'h0;
    end else if (jump) begin
      mq.delete();
      mpc = jaddr & 32'hFFFF_FFFC;
    end else begin
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (mq.size() < FD) begin
        mq.push_back('{mpc, rom_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    check("m_valid", 64'(valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("m_instr", 64'(instr), 64'(mq[0].instr));
      check("m_pc", 64'(instr_pc), 64'(mq[0].pc));
    end else begin
      check("m_nop", 64'(instr), 64'h13);
      check("m_pc0", 64'(instr_pc), 64'h0);
    end
    check("m_romaddr", 64'(rom_addr), 64'((mpc >> 2) % RD));
    tests++;
    if (dut.u_fifo.count_q > 3'(FD)) begin
      fails++;
      $display("FAIL count_bound: got %0d limit %0d", dut.u_fifo.count_q, FD);
    end
  end

  initial begin
    #3;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_instr", 64'(instr), 64'h13);
    check("rst_pc", 64'(instr_pc), 64'h0);
    check("rst_romaddr", 64'(rom_addr), 64'h0);
    tick(); tick();
    rstn = 1'b1; ready = 1'b1;
    tick(); check_head("first0", 32'h1000_0000, 32'h0);
    tick(); check_head("first1", 32'h1000_0001, 32'h4);
    tick(); check_head("first2", 32'h1000_0002, 32'h8);

    // Stall until full
    rstn = 1'b0; ready = 1'b0;
    tick(); rstn = 1'b1;
    repeat (10) tick();
    check("stall_romaddr", 64'(rom_addr), 64'h4);
    check_head("stall_head", 32'h1000_0000, 32'h0);
    ready = 1'b1;
    tick(); check_head("drain1", 32'h1000_0001, 32'h4);
    tick(); check_head("drain2", 32'h1000_0002, 32'h8);

    // Redirect with full queue and ready high
    ready = 1'b0;
    tick(); check_head("full_hold", 32'h1000_0002, 32'h8);
    ready = 1'b1; jump = 1'b1; jaddr = 32'h40;
    tick(); jump = 1'b0;
    check("jmp_bubble", 64'(valid), 64'd0);
    check("jmp_romaddr", 64'(rom_addr), 64'h10);
    tick(); check_head("jmp_tgt", 32'h1000_0010, 32'h40);

    jump = 1'b1; jaddr = 32'h43;
    tick(); jump = 1'b0;
    check("align_romaddr", 64'(rom_addr), 64'h10);
    tick(); check_head("align_tgt", 32'h1000_0010, 32'h40);
    jump = 1'b1; jaddr = 32'h400;
    tick(); jump = 1'b0;
    check("romwrap_addr", 64'(rom_addr), 64'h0);
    tick(); check_head("romwrap_tgt", 32'h1000_0000, 32'h400);

    // 32-bit PC wrap
    jump = 1'b1; jaddr = 32'hFFFF_FFF8;
    tick(); jump = 1'b0;
    tick(); check_head("pcwrap0", 32'h1000_00FE, 32'hFFFF_FFF8);
    tick(); check_head("pcwrap1", 32'h1000_00FF, 32'hFFFF_FFFC);
    tick(); check_head("pcwrap2", 32'h1000_0000, 32'h0);

    // Reset with three entries queued
    jump = 1'b1; jaddr = 32'h80; ready = 1'b0;
    tick(); jump = 1'b0;
    repeat (3) tick();
    check_head("pre_rst", 32'h1000_0020, 32'h80);
    #1 rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_instr", 64'(instr), 64'h13);
    check("midrst_pc", 64'(instr_pc), 64'h0);
    tick(); rstn = 1'b1; ready = 1'b1;
    tick(); check_head("restart", 32'h1000_0000, 32'h0);

    repeat (10000) begin
      ready = ($urandom_range(0, 3) != 0);
      jump  = ($urandom_range(0, 19) == 0);
      jaddr = $urandom;
      tick();
    end
    jump = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
